tile_scan_scheduler: RTL and testbench

- Time-multiplexes the shared 8-bit output byte of the micro-tile container across its N_TILES projects (sensor, TDC, RO, RO2).
- Drives the tile-select index and waits a settle time after each switch.
- Averages (sums) a burst of samples per tile and publishes one tagged result per tile over a valid/ready stream.
- Sits between the container output mux and the readout/serialiser logic; single-shot or continuous round-robin scans.

---
 rtl/tile_scan_scheduler_pkg.sv | 24 ++
 rtl/tile_scan_scheduler_rr_next.sv | 41 ++++
 rtl/tile_scan_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_tile_scan_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_scan_scheduler_pkg.sv
// Shared types and sizing helpers for the tile scan scheduler.
package tile_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_SAMPLE  = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

  localparam int DATA_W = 8;
  localparam int AVG_LOG2_MAX = 6;
  localparam int ACC_W_MAX = DATA_W + AVG_LOG2_MAX;

  function automatic int sel_width(input int n_tiles);
    return (n_tiles <= 2) ? 1 : $clog2(n_tiles);
  endfunction

  // A sum of 2^avg_log2 bytes needs exactly avg_log2 extra bits.
  function automatic int acc_width(input int avg_log2);
    return DATA_W + avg_log2;
  endfunction

endpackage

// File: rtl/tile_scan_scheduler_rr_next.sv
// Combinational round-robin helper: next enabled tile above the current
// index (with wrap flag), plus the lowest enabled tile of the mask.
module tile_rr_next
  import tile_sched_pkg::*;
#(
  parameter int N_TILES = 4,
  parameter int SEL_W   = sel_width(N_TILES)
) (
  input  logic [N_TILES-1:0] i_mask,
  input  logic [SEL_W-1:0]   i_cur,
  output logic [SEL_W-1:0]   o_next,
  output logic               o_wrap,
  output logic [SEL_W-1:0]   o_lowest,
  output logic               o_any
);

  logic [N_TILES-1:0] w_above;

  for (genvar gi = 0; gi < N_TILES; gi++) begin : g_above
    assign w_above[gi] = i_mask[gi] && (int'(i_cur) < gi);
  end

  // Scanning downward leaves the lowest qualifying index as the final value.
  always_comb begin
    o_next   = '0;
    o_wrap   = 1'b1;
    o_lowest = '0;
    for (int i = N_TILES - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_lowest = SEL_W'(i);
      end
      if (w_above[i]) begin
        o_next = SEL_W'(i);
        o_wrap = 1'b0;
      end
    end
  end

  assign o_any = |i_mask;

endmodule

// File: rtl/tile_scan_scheduler.sv
// Tile scan scheduler: selects each enabled tile, settles, sums a burst of
// samples and publishes a tagged result. Optional timestamp: TILE_TSTAMP_EN.
module tile_scan_scheduler
  import tile_sched_pkg::*;
#(
  parameter int N_TILES       = 4,
  parameter int SEL_W         = sel_width(N_TILES),
  parameter int SETTLE_CYCLES = 4,
  parameter int AVG_LOG2      = 2,
  parameter int TS_W          = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       continuous,
  input  logic [N_TILES-1:0]         tile_mask,
  input  logic [DATA_W-1:0]          tile_data,
  output logic [SEL_W-1:0]           sel,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [SEL_W-1:0]           res_tile,
  output logic [DATA_W+AVG_LOG2-1:0] res_data,
  output logic                       busy,
  output logic                       done
`ifdef TILE_TSTAMP_EN
  ,
  output logic [TS_W-1:0]            res_ts
`endif
);

  localparam int ACC_W     = acc_width(AVG_LOG2);
  localparam int N_SAMPLES = 1 << AVG_LOG2;
  localparam int CNT_MAX   = (SETTLE_CYCLES > N_SAMPLES) ? SETTLE_CYCLES : N_SAMPLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  // A pass launched from IDLE spends one extra settle cycle, because the
  // start edge itself is where the mask is captured.
  localparam logic [CNT_W-1:0] CNT_LAUNCH = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(N_SAMPLES - 1);

  state_t             r_state;
  logic [N_TILES-1:0] r_mask;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [SEL_W-1:0]   r_sel;
  logic               r_res_valid;
  logic [SEL_W-1:0]   r_res_tile;
  logic [ACC_W-1:0]   r_res_data;
  logic               r_done;

  logic [SEL_W-1:0]   w_next;
  logic               w_wrap;
  logic [SEL_W-1:0]   w_new_lowest;
  logic               w_new_any;
  logic [ACC_W-1:0]   w_acc_sum;
  logic [SEL_W-1:0]   w_pass_lowest_unused;
  logic               w_pass_any_unused;
  logic [SEL_W-1:0]   w_new_next_unused;
  logic               w_new_wrap_unused;

  tile_rr_next #(
    .N_TILES (N_TILES),
    .SEL_W   (SEL_W)
  ) u_rr_pass (
    .i_mask   (r_mask),
    .i_cur    (r_sel),
    .o_next   (w_next),
    .o_wrap   (w_wrap),
    .o_lowest (w_pass_lowest_unused),
    .o_any    (w_pass_any_unused)
  );

  // Looks at the live mask: used at start and at every pass boundary.
  tile_rr_next #(
    .N_TILES (N_TILES),
    .SEL_W   (SEL_W)
  ) u_rr_new (
    .i_mask   (tile_mask),
    .i_cur    (r_sel),
    .o_next   (w_new_next_unused),
    .o_wrap   (w_new_wrap_unused),
    .o_lowest (w_new_lowest),
    .o_any    (w_new_any)
  );

  assign w_acc_sum = r_acc + ACC_W'(tile_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_sel       <= '0;
      r_res_valid <= 1'b0;
      r_res_tile  <= '0;
      r_res_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && w_new_any) begin
            r_mask  <= tile_mask;
            r_sel   <= w_new_lowest;
            r_cnt   <= CNT_LAUNCH;
            r_state <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_cnt   <= CNT_SAMPLE;
            r_acc   <= '0;
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        // The final sample is folded straight into the published result.
        ST_SAMPLE: begin
          r_acc <= w_acc_sum;
          if (r_cnt == '0) begin
            r_res_data  <= w_acc_sum;
            r_res_tile  <= r_sel;
            r_res_valid <= 1'b1;
            r_state     <= ST_PUBLISH;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_PUBLISH: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_cnt       <= CNT_SETTLE;
            if (!w_wrap) begin
              r_sel   <= w_next;
              r_state <= ST_SETTLE;
            end else if (continuous) begin
              r_mask <= tile_mask;
              if (w_new_any) begin
                r_sel   <= w_new_lowest;
                r_state <= ST_SETTLE;
              end else begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
              end
            end else begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sel       = r_sel;
  assign res_valid = r_res_valid;
  assign res_tile  = r_res_tile;
  assign res_data  = r_res_data;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;

`ifdef TILE_TSTAMP_EN
  logic [TS_W-1:0] r_ts_cnt;
  logic [TS_W-1:0] r_ts_first;
  logic [TS_W-1:0] r_res_ts;
  logic [TS_W-1:0] w_ts_first;

  // On the first sample cycle the live counter is the stamp to keep.
  assign w_ts_first = (r_cnt == CNT_SAMPLE) ? r_ts_cnt : r_ts_first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts_cnt   <= '0;
      r_ts_first <= '0;
      r_res_ts   <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + TS_W'(1);
      if (r_state == ST_SAMPLE) begin
        r_ts_first <= w_ts_first;
        if (r_cnt == '0) begin
          r_res_ts <= w_ts_first;
        end
      end
    end
  end

  assign res_ts = r_res_ts;
`endif

endmodule

// File: tb/tb_tile_scan_scheduler.sv
// Self-checking bench for tile_scan_scheduler: directed scenarios plus
// randomized masks, tile bytes and backpressure against a per-pass model.
module tb_tile_scan_scheduler;

  localparam int N_TILES       = 4;
  localparam int SEL_W         = 2;
  localparam int SETTLE_CYCLES = 4;
  localparam int AVG_LOG2      = 2;
  localparam int TS_W          = 16;
  localparam int N_SAMP        = 1 << AVG_LOG2;
  localparam int LAT           = SETTLE_CYCLES + N_SAMP + 1;
  localparam int RES_W         = 8 + AVG_LOG2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               continuous = 1'b0;
  logic               res_ready = 1'b0;
  logic [N_TILES-1:0] tile_mask = '0;
  logic [7:0]         tile_data;
  logic [7:0]         data_drv = 8'd0;
  logic               use_mux = 1'b0;
  logic [7:0]         tile_val [N_TILES];
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   res_tile;
  logic               res_valid;
  logic               busy;
  logic               done;
  logic [RES_W-1:0]   res_data;
`ifdef TILE_TSTAMP_EN
  logic [TS_W-1:0]    res_ts;
  logic [TS_W-1:0]    ts0;
  logic [TS_W-1:0]    ts_delta;
`endif

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int hs_before;
  int done_before;
  int nres;
  int done_k;
  int phase;
  logic cleared;
  logic [N_TILES-1:0] cur_mask = '0;
  logic [N_TILES-1:0] rmask;
  logic [SEL_W-1:0]   exp_tile_q[$];
  int                 exp_data_q[$];

  always #5 clk = ~clk;

  // Container output mux model: the byte of whichever tile is selected.
  assign tile_data = use_mux ? tile_val[sel] : data_drv;

  tile_scan_scheduler #(
    .N_TILES       (N_TILES),
    .SEL_W         (SEL_W),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .AVG_LOG2      (AVG_LOG2),
    .TS_W          (TS_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .continuous (continuous),
    .tile_mask  (tile_mask),
    .tile_data  (tile_data),
    .sel        (sel),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_tile   (res_tile),
    .res_data   (res_data),
    .busy       (busy),
    .done       (done)
`ifdef TILE_TSTAMP_EN
    ,
    .res_ts     (res_ts)
`endif
  );

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (res_valid === 1'b1 && res_ready === 1'b1) hs_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [N_TILES-1:0] m);
    tile_mask = m;
    cur_mask  = m;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (res_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, res_valid, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic expect_pass(input logic [N_TILES-1:0] m, input int per_tile_sum, input logic use_vals);
    for (int t = 0; t < N_TILES; t++) begin
      if (m[t]) begin
        exp_tile_q.push_back(SEL_W'(t));
        exp_data_q.push_back(use_vals ? int'(tile_val[t]) * N_SAMP : per_tile_sum);
      end
    end
  endtask

  task automatic collect(input int ready_pct, input int budget);
    int n = 0;
    logic held = 1'b0;
    logic [SEL_W-1:0] h_tile = '0;
    logic [RES_W-1:0] h_data = '0;
    while (exp_tile_q.size() != 0 && n < budget) begin
      res_ready = ($urandom_range(99) < ready_pct);
      if (busy === 1'b1) check("sel_enabled", cur_mask[sel], 1);
      if (res_valid === 1'b1) begin
        if (held) begin
          check("hold_tile", res_tile, h_tile);
          check("hold_data", res_data, h_data);
        end
        if (res_ready) begin
          $display("result tile=%0d data=%0h", res_tile, res_data);
          check("res_tile", res_tile, exp_tile_q[0]);
          check("res_data", res_data, exp_data_q[0]);
          void'(exp_tile_q.pop_front());
          void'(exp_data_q.pop_front());
          held = 1'b0;
        end else begin
          held   = 1'b1;
          h_tile = res_tile;
          h_data = res_data;
        end
      end else begin
        held = 1'b0;
      end
      tick();
      n++;
    end
    res_ready = 1'b0;
    check("collect_drained", exp_tile_q.size(), 0);
  endtask

  initial begin
    for (int t = 0; t < N_TILES; t++) tile_val[t] = 8'd0;

    // Reset state
    tick();
    tick();
    check("rst_sel", sel, 0);
    check("rst_valid", res_valid, 0);
    check("rst_tile", res_tile, 0);
    check("rst_data", res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_after_reset", busy, 0);

    // Empty mask: start ignored
    pulse_start(4'b0000);
    start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    start = 1'b0;
    check("mask0_busy", busy, 0);
    check("mask0_done", done_cnt, 0);

    // Single shot 1011 with constant byte, latency and done
    data_drv  = 8'h10;
    res_ready = 1'b1;
    pulse_start(4'b1011);
    for (int i = 1; i < LAT; i++) tick();
    check("lat_early", res_valid, 0);
    tick();
    check("lat_exact", res_valid, 1);
    expect_pass(4'b1011, 'h40, 1'b0);
    collect(100, 100);
    check("single_done", done, 1);
    check("single_idle", busy, 0);
    tick();
    check("done_one_cycle", done, 0);

    // Backpressure hold then advance
    res_ready = 1'b0;
    pulse_start(4'b1011);
    wait_valid("bp_wait", 30);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", res_valid, 1);
      check("bp_tile", res_tile, 0);
      check("bp_data", res_data, 'h40);
      check("bp_sel", sel, 0);
    end
    res_ready = 1'b1;
    tick();
    check("bp_valid_drop", res_valid, 0);
    check("bp_sel_adv", sel, 1);
    expect_pass(4'b0010, 'h40, 1'b0);
    expect_pass(4'b1000, 'h40, 1'b0);
    collect(100, 100);
    check("bp_done", done, 1);
    tick();

    // Continuous single tile, ramp 1..N per sample window
    continuous = 1'b1;
    res_ready  = 1'b1;
    data_drv   = 8'd0;
    pulse_start(4'b0001);
    nres    = 0;
    done_k  = -1;
    cleared = 1'b0;
    for (int k = 1; k <= 5 * LAT && done_k < 0; k++) begin
      phase    = (k - (SETTLE_CYCLES + 1)) % LAT;
      data_drv = (phase >= 1 && phase <= N_SAMP) ? 8'(phase) : 8'd0;
      tick();
      if (res_valid === 1'b1) begin
        nres++;
        $display("ramp result %0d at edge %0d data=%0d", nres, k, res_data);
        check("ramp_data", res_data, N_SAMP * (N_SAMP + 1) / 2);
        check("ramp_edge", k, nres * LAT);
        check("ramp_sel", sel, 0);
      end
      if (nres == 2 && !cleared && res_valid !== 1'b1) begin
        continuous = 1'b0;
        cleared    = 1'b1;
      end
      if (done === 1'b1) done_k = k;
    end
    check("ramp_results", nres, 3);
    check("ramp_done_edge", done_k, 3 * LAT + 1);
    check("ramp_idle", busy, 0);

`ifdef TILE_TSTAMP_EN
    // Consecutive stamps differ by one tile period
    res_ready = 1'b1;
    data_drv  = 8'd1;
    pulse_start(4'b0011);
    wait_valid("ts_wait0", 30);
    ts0 = res_ts;
    tick();
    wait_valid("ts_wait1", 30);
    ts_delta = res_ts - ts0;
    $display("tstamp delta=%0d", ts_delta);
    check("ts_delta", ts_delta, LAT);
    tick();
    wait_idle("ts_idle", 10);
`endif

    // Randomized masks, tile bytes and backpressure; start held while busy
    use_mux = 1'b1;
    for (int it = 0; it < 6; it++) begin
      rmask = N_TILES'($urandom_range(15, 1));
      for (int t = 0; t < N_TILES; t++) tile_val[t] = 8'($urandom_range(255));
      expect_pass(rmask, 0, 1'b1);
      res_ready = 1'b0;
      hs_before = hs_cnt;
      pulse_start(rmask);
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      collect(60, 800);
      check("rand_done", done, 1);
      for (int i = 0; i < 12; i++) tick();
      check("rand_idle", busy, 0);
      check("rand_count", hs_cnt - hs_before, $countones(rmask));
    end
    use_mux = 1'b0;

    // Asynchronous reset mid-SAMPLE
    data_drv  = 8'h55;
    res_ready = 1'b1;
    pulse_start(4'b1100);
    for (int i = 0; i < 6; i++) tick();
    check("pre_reset_busy", busy, 1);
    done_before = done_cnt;
    rst_n = 1'b0;
    #1;
    check("arst_sel", sel, 0);
    check("arst_valid", res_valid, 0);
    check("arst_tile", res_tile, 0);
    check("arst_data", res_data, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("post_reset_idle", busy, 0);
    check("post_reset_valid", res_valid, 0);
    check("post_reset_no_done", done_cnt - done_before, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
